// File: rtl/ingress_frame_packer_pkg.sv
// Shared definitions for the ingress frame packer and its egress peers.
// Holds the frame size limits, the 128-bit packed word format, the packer
// FSM state type and the beat byte-count clamp used by the lane aligner.
package ingress_frame_packer_pkg;

  localparam int MAX_FRAME_LEN  = 1518;
  localparam int FRAME_LEN_BITS = 11;

  // One FIFO word: 16 bytes MSB-first plus frame-end metadata.
  typedef struct packed {
    logic [127:0]                data;
    logic                        last;
    logic [FRAME_LEN_BITS-1:0]   len;
    logic                        drop;
  } pkt_word_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCEPT  = 2'd1,
    ST_DISCARD = 2'd2,
    ST_FLUSH   = 2'd3
  } pk_state_t;

  // A beat carries at most 4 bytes; anything larger is treated as 4.
  function automatic logic [2:0] clamp_bytes(input logic [2:0] bv);
    return (bv > 3'd4) ? 3'd4 : bv;
  endfunction

endpackage

// File: rtl/ingress_frame_packer_if.sv
// MAC receive bus between a port MAC (master) and the ingress packer (slave).
//   start       : first cycle of a frame (carries no data)
//   data_valid  : data[31 -: 8*bytes_valid] holds valid bytes this beat
//   bytes_valid : 1..4 bytes on this beat
//   commit/drop : frame end, good or bad
interface ingress_frame_packer_if;
  logic        start;
  logic        data_valid;
  logic [31:0] data;
  logic [2:0]  bytes_valid;
  logic        commit;
  logic        drop;

  modport master (output start, data_valid, data, bytes_valid, commit, drop);
  modport slave  (input  start, data_valid, data, bytes_valid, commit, drop);
endinterface

// File: rtl/ingress_frame_packer_aligner.sv
// Byte lane aligner: merges one MAC beat into a partially filled 16-byte
// accumulator. Combinational.
//   base_acc/base_fill : current accumulator and its fill (0..15 bytes)
//   beat_*             : incoming beat
//   merged_acc         : accumulator with the beat appended
//   spill_bytes/cnt    : bytes past the 16-byte boundary (0..3)
//   merged_fill        : new fill when not full
//   word_full          : accumulator reached 16 bytes
module ingress_frame_packer_aligner
  import ingress_frame_packer_pkg::*;
(
  input  logic [127:0] base_acc,
  input  logic [3:0]   base_fill,
  input  logic [31:0]  beat_data,
  input  logic [2:0]   beat_bytes,
  input  logic         beat_valid,
  output logic [127:0] merged_acc,
  output logic [23:0]  spill_bytes,
  output logic [1:0]   spill_cnt,
  output logic [3:0]   merged_fill,
  output logic         word_full
);

  logic [2:0]   nbytes;
  logic [31:0]  beat_masked;
  logic [151:0] ext;
  logic [4:0]   total;

  always_comb begin
    nbytes      = beat_valid ? clamp_bytes(beat_bytes) : 3'd0;
    // Keep only the top nbytes of the beat so unused trailing bytes stay zero.
    beat_masked = beat_data & ~(32'hFFFF_FFFF >> {nbytes, 3'b000});
    // 19-byte window: 16 accumulator bytes plus up to 3 spill bytes.
    ext         = {base_acc, 24'd0} | ({beat_masked, 120'd0} >> {base_fill, 3'b000});
    total       = {1'b0, base_fill} + {2'b00, nbytes};
    word_full   = (total >= 5'd16);
    merged_acc  = ext[151:24];
    spill_bytes = ext[23:0];
    spill_cnt   = word_full ? total[1:0] : 2'd0;
    merged_fill = total[3:0];
  end

endmodule

// File: rtl/ingress_frame_packer.sv
// Per-port ingress packer: packs MAC receive beats into 128-bit big-endian
// FIFO words with last/len/drop metadata.
//   clk, rst_n   : port RX clock, async active-low reset
//   rx_bus       : MAC receive bus (slave side)
//   space_avail  : downstream can take a max-size frame; sampled at start
//   out_*        : registered packed word stream
//   drop_count   : saturating count of refused or dropped frames
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | between frames, waiting for start
// ST_ACCEPT  | frame accepted, packing beats
// ST_DISCARD | frame refused or truncated, swallowing beats until end
// ST_FLUSH   | emitting the spill remainder as the last word
module ingress_frame_packer
  import ingress_frame_packer_pkg::*;
#(
  parameter int MAX_LEN  = MAX_FRAME_LEN,
  parameter int LEN_BITS = FRAME_LEN_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ingress_frame_packer_if.slave  rx_bus,
  input  logic                   space_avail,
  output logic                   out_valid,
  output logic [127:0]           out_data,
  output logic                   out_last,
  output logic [LEN_BITS-1:0]    out_len,
  output logic                   out_drop,
  output logic [31:0]            drop_count
);

  localparam logic [LEN_BITS:0]   MAX_LEN_W = (LEN_BITS+1)'(MAX_LEN);
  localparam logic [LEN_BITS-1:0] MAX_LEN_L = LEN_BITS'(MAX_LEN);

  pk_state_t           state_q, state_d;
  logic [127:0]        acc_q, acc_d;
  logic [3:0]          fill_q, fill_d;
  logic                full_q, full_d;   // accumulator holds a full word
  logic [23:0]         spill_q, spill_d;
  logic [1:0]          spill_cnt_q, spill_cnt_d;
  logic [LEN_BITS-1:0] count_q, count_d;
  logic [31:0]         drop_count_q, drop_count_d;
  logic                out_valid_q, out_valid_d;
  pkt_word_t           out_q, out_d;

  logic [127:0]        al_acc;
  logic [23:0]         al_spill;
  logic [1:0]          al_spill_cnt;
  logic [3:0]          al_fill;
  logic                al_full;
  logic [LEN_BITS:0]   count_sum;
  logic [1:0]          drop_inc;
  logic [32:0]         drop_sum;
  logic                clear_frame;
  logic                pre_emit;

  function automatic pkt_word_t mk_word(input logic [127:0] d, input logic l,
                                        input logic [LEN_BITS-1:0] n, input logic dr);
    pkt_word_t w;
    w.data = d;
    w.last = l;
    w.len  = FRAME_LEN_BITS'(n);
    w.drop = dr;
    return w;
  endfunction

  // A held full word is emitted before new bytes land, so new bytes merge
  // onto the spill remainder instead of the accumulator.
  ingress_frame_packer_aligner u_aligner (
    .base_acc    (full_q ? {spill_q, 104'd0} : acc_q),
    .base_fill   (full_q ? {2'b00, spill_cnt_q} : fill_q),
    .beat_data   (rx_bus.data),
    .beat_bytes  (rx_bus.bytes_valid),
    .beat_valid  (rx_bus.data_valid),
    .merged_acc  (al_acc),
    .spill_bytes (al_spill),
    .spill_cnt   (al_spill_cnt),
    .merged_fill (al_fill),
    .word_full   (al_full)
  );

  assign count_sum = {1'b0, count_q} + (LEN_BITS+1)'(clamp_bytes(rx_bus.bytes_valid));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    full_d      = full_q;
    spill_d     = spill_q;
    spill_cnt_d = spill_cnt_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    out_d       = '0;
    drop_inc    = 2'd0;
    clear_frame = 1'b0;
    pre_emit    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DISCARD: begin
        if (rx_bus.start) begin
          clear_frame = 1'b1;
          if (space_avail) begin
            state_d = ST_ACCEPT;
          end else begin
            state_d  = ST_DISCARD;
            drop_inc = 2'd1;
          end
        end else if (state_q == ST_DISCARD && (rx_bus.commit || rx_bus.drop)) begin
          state_d = ST_IDLE;
        end
      end

      ST_FLUSH: begin
        out_valid_d = 1'b1;
        out_d       = mk_word(acc_q, 1'b1, count_q, 1'b0);
        clear_frame = 1'b1;
        if (rx_bus.start) begin
          state_d  = ST_DISCARD;
          drop_inc = 2'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCEPT: begin
        if (rx_bus.start) begin
          // Missing end: close the old frame as dropped, then take the start.
          out_valid_d = 1'b1;
          out_d       = mk_word(acc_q, 1'b1, count_q, 1'b1);
          clear_frame = 1'b1;
          if (space_avail) begin
            drop_inc = 2'd1;
          end else begin
            drop_inc = 2'd2;
            state_d  = ST_DISCARD;
          end
        end else if (rx_bus.drop) begin
          out_valid_d = 1'b1;
          out_d       = mk_word(acc_q, 1'b1, count_q, 1'b1);
          drop_inc    = 2'd1;
          clear_frame = 1'b1;
          state_d     = ST_IDLE;
        end else if (rx_bus.data_valid && count_sum > MAX_LEN_W) begin
          out_valid_d = 1'b1;
          out_d       = mk_word(acc_q, 1'b1, MAX_LEN_L, 1'b1);
          drop_inc    = 2'd1;
          clear_frame = 1'b1;
          state_d     = rx_bus.commit ? ST_IDLE : ST_DISCARD;
        end else begin
          if (rx_bus.data_valid) begin
            pre_emit = full_q;
            if (full_q) begin
              out_valid_d = 1'b1;
              out_d       = mk_word(acc_q, 1'b0, '0, 1'b0);
            end
            acc_d       = al_acc;
            fill_d      = al_fill;
            full_d      = al_full;
            spill_d     = al_spill;
            spill_cnt_d = al_spill_cnt;
            count_d     = count_sum[LEN_BITS-1:0];
          end
          if (rx_bus.commit) begin
            if (count_d == '0) begin
              out_valid_d = 1'b1;
              out_d       = mk_word('0, 1'b1, '0, 1'b1);
              drop_inc    = 2'd1;
              clear_frame = 1'b1;
              state_d     = ST_IDLE;
            end else if (pre_emit) begin
              // Held word already going out; the merged tail (<=7 bytes) follows.
              state_d = ST_FLUSH;
            end else if (spill_cnt_d != 2'd0) begin
              out_valid_d = 1'b1;
              out_d       = mk_word(acc_d, 1'b0, '0, 1'b0);
              acc_d       = {spill_d, 104'd0};
              state_d     = ST_FLUSH;
            end else begin
              out_valid_d = 1'b1;
              out_d       = mk_word(acc_d, 1'b1, count_d, 1'b0);
              clear_frame = 1'b1;
              state_d     = ST_IDLE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (clear_frame) begin
      acc_d       = '0;
      fill_d      = '0;
      full_d      = 1'b0;
      spill_d     = '0;
      spill_cnt_d = '0;
      count_d     = '0;
    end

    drop_sum     = {1'b0, drop_count_q} + {31'd0, drop_inc};
    drop_count_d = drop_sum[32] ? '1 : drop_sum[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      fill_q       <= '0;
      full_q       <= 1'b0;
      spill_q      <= '0;
      spill_cnt_q  <= '0;
      count_q      <= '0;
      drop_count_q <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      full_q       <= full_d;
      spill_q      <= spill_d;
      spill_cnt_q  <= spill_cnt_d;
      count_q      <= count_d;
      drop_count_q <= drop_count_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_q.data;
  assign out_last   = out_q.last;
  assign out_len    = LEN_BITS'(out_q.len);
  assign out_drop   = out_q.drop;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_ingress_frame_packer.sv
module tb_ingress_frame_packer;

  typedef struct {
    logic [127:0] data;
    logic         last;
    logic [10:0]  len;
    logic         drop;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         space_avail;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_last;
  logic [10:0]  out_len;
  logic         out_drop;
  logic [31:0]  drop_count;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   exp_drops = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ingress_frame_packer_if rx_if ();

  ingress_frame_packer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_bus      (rx_if),
    .space_avail (space_avail),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_len     (out_len),
    .out_drop    (out_drop),
    .drop_count  (drop_count)
  );

  // Scoreboard: every emitted word is matched against the next expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_word: got data=%h last=%b len=%0d drop=%b, required no out_valid",
                 out_data, out_last, out_len, out_drop);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_data !== e.data || out_last !== e.last ||
            (e.last && (out_len !== e.len || out_drop !== e.drop))) begin
          tests_failed++;
          $display("FAIL word: got data=%h last=%b len=%0d drop=%b, required data=%h last=%b len=%0d drop=%b",
                   out_data, out_last, out_len, out_drop, e.data, e.last, e.len, e.drop);
        end
      end
    end
  end

  // Reference packing: bytes chunked 16 per word, MSB-first, zero padded.
  task automatic exp_frame(input logic [7:0] b[$], input bit with_last, input int len, input bit dr);
    exp_t e;
    int   n;
    int   nw;
    n  = b.size();
    nw = with_last ? ((n == 0) ? 1 : (n + 15) / 16) : n / 16;
    for (int w = 0; w < nw; w++) begin
      e.data = '0;
      for (int k = 0; k < 16; k++)
        if (16 * w + k < n) e.data[127 - 8 * k -: 8] = b[16 * w + k];
      e.last = with_last && (w == nw - 1);
      e.len  = e.last ? 11'(len) : 11'd0;
      e.drop = e.last && dr;
      exp_q.push_back(e);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic [2:0] bv, input logic dv,
                      input logic st, input logic cm, input logic dr);
    rx_if.start       = st;
    rx_if.data_valid  = dv;
    rx_if.data        = d;
    rx_if.bytes_valid = bv;
    rx_if.commit      = cm;
    rx_if.drop        = dr;
    @(posedge clk);
    #1;
    rx_if.start       = 1'b0;
    rx_if.data_valid  = 1'b0;
    rx_if.data        = '0;
    rx_if.bytes_valid = '0;
    rx_if.commit      = 1'b0;
    rx_if.drop        = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input int bpb, input bit commit_last);
    int          nb;
    logic [31:0] d;
    for (int i = 0; i < b.size(); i += bpb) begin
      nb = (b.size() - i < bpb) ? b.size() - i : bpb;
      d  = '0;
      for (int k = 0; k < nb; k++) d[31 - 8 * k -: 8] = b[i + k];
      beat(d, 3'(nb), 1'b1, 1'b0, commit_last && (i + nb >= b.size()), 1'b0);
    end
  endtask

  // Bounded wait for the scoreboard to empty, plus idle slack for strays.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
        out_len !== '0 || out_drop !== 1'b0 || drop_count !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b data=%h last=%b len=%0d drop=%b cnt=%0d, required all 0",
               out_valid, out_data, out_last, out_len, out_drop, drop_count);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_one_byte_beats();
    logic [7:0] b[$];
    for (int i = 0; i < 64; i++) b.push_back(8'(i));
    exp_frame(b, 1, 64, 0);
    beat('0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bytes(b, 1, 0);
    beat('0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL one_byte_drain: %0d words missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_four_byte_partial();
    logic [7:0] b[$];
    for (int i = 0; i < 61; i++) b.push_back(8'(8'hA0 + i));
    exp_frame(b, 1, 61, 0);
    beat('0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bytes(b, 4, 1);
    drain();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL four_byte_drain: %0d words missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_spill_flush();
    logic [7:0] b[$];
    logic [7:0] two[$];
    logic [7:0] rest[$];
    for (int i = 0; i < 18; i++) b.push_back(8'(i * 7 + 1));
    for (int i = 0; i < 2; i++) two.push_back(b[i]);
    for (int i = 2; i < 18; i++) rest.push_back(b[i]);
    exp_frame(b, 1, 18, 0);
    beat('0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bytes(two, 2, 0);
    send_bytes(rest, 4, 0);
    beat('0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL spill_drain: %0d words missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_no_space();
    logic [7:0] b[$];
    for (int i = 0; i < 100; i++) b.push_back(8'(i));
    space_avail = 1'b0;
    beat('0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    space_avail = 1'b1;
    send_bytes(b, 4, 1);
    exp_drops++;
    drain();
    tests_run++;
    if (drop_count !== 32'(exp_drops)) begin
      tests_failed++;
      $display("FAIL no_space_drop_count: got %0d, required %0d", drop_count, exp_drops);
    end
  endtask

  task automatic test_oversize();
    logic [7:0] b[$];
    logic [7:0] kept[$];
    for (int i = 0; i < 1600; i++) b.push_back(8'(i * 3));
    for (int i = 0; i < 1516; i++) kept.push_back(b[i]);
    exp_frame(kept, 1, 1518, 1);
    beat('0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bytes(b, 4, 1);
    exp_drops++;
    drain();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL oversize_drain: %0d words missing, required 0", exp_q.size());
      exp_q.delete();
    end
    tests_run++;
    if (drop_count !== 32'(exp_drops)) begin
      tests_failed++;
      $display("FAIL oversize_drop_count: got %0d, required %0d", drop_count, exp_drops);
    end
  endtask

  task automatic test_drop_frame();
    logic [7:0] b[$];
    for (int i = 0; i < 20; i++) b.push_back(8'(8'h55 ^ i));
    exp_frame(b, 1, 20, 1);
    beat('0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bytes(b, 4, 0);
    beat('0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_drops++;
    drain();
    tests_run++;
    if (exp_q.size() != 0 || drop_count !== 32'(exp_drops)) begin
      tests_failed++;
      $display("FAIL drop_frame: got %0d words left, drop_count %0d, required 0 and %0d",
               exp_q.size(), drop_count, exp_drops);
      exp_q.delete();
    end
  endtask

  task automatic test_empty_commit();
    logic [7:0] b[$];
    exp_frame(b, 1, 0, 1);
    beat('0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    beat('0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_drops++;
    drain();
    tests_run++;
    if (exp_q.size() != 0 || drop_count !== 32'(exp_drops)) begin
      tests_failed++;
      $display("FAIL empty_commit: got %0d words left, drop_count %0d, required 0 and %0d",
               exp_q.size(), drop_count, exp_drops);
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back_start();
    logic [7:0] a[$];
    logic [7:0] c[$];
    for (int i = 0; i < 8; i++) a.push_back(8'(8'h10 + i));
    for (int i = 0; i < 8; i++) c.push_back(8'(8'hC0 + i));
    exp_frame(a, 1, 8, 1);
    exp_frame(c, 1, 8, 0);
    beat('0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bytes(a, 4, 0);
    beat('0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bytes(c, 4, 0);
    beat('0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_drops++;
    drain();
    tests_run++;
    if (exp_q.size() != 0 || drop_count !== 32'(exp_drops)) begin
      tests_failed++;
      $display("FAIL restart: got %0d words left, drop_count %0d, required 0 and %0d",
               exp_q.size(), drop_count, exp_drops);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b[$];
    logic [7:0] first[$];
    logic [7:0] clean[$];
    for (int i = 0; i < 40; i++) b.push_back(8'(8'hE0 - i));
    for (int i = 0; i < 32; i++) first.push_back(b[i]);
    for (int i = 0; i < 64; i++) clean.push_back(8'(i));
    exp_frame(first, 0, 0, 0);
    beat('0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bytes(b, 1, 0);
    drain();
    rst_n = 1'b0;
    exp_drops = 0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
        out_len !== '0 || out_drop !== 1'b0 || drop_count !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got valid=%b data=%h last=%b len=%0d drop=%b cnt=%0d, required all 0",
               out_valid, out_data, out_last, out_len, out_drop, drop_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_frame(clean, 1, 64, 0);
    beat('0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bytes(clean, 1, 1);
    drain();
    tests_run++;
    if (exp_q.size() != 0 || drop_count !== 32'(exp_drops)) begin
      tests_failed++;
      $display("FAIL after_reset_frame: got %0d words left, drop_count %0d, required 0 and %0d",
               exp_q.size(), drop_count, exp_drops);
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    space_avail       = 1'b1;
    rx_if.start       = 1'b0;
    rx_if.data_valid  = 1'b0;
    rx_if.data        = '0;
    rx_if.bytes_valid = '0;
    rx_if.commit      = 1'b0;
    rx_if.drop        = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_one_byte_beats();
    test_four_byte_partial();
    test_spill_flush();
    test_no_space();
    test_oversize();
    test_drop_frame();
    test_empty_commit();
    test_back_to_back_start();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
